uart_rx_buffer: RTL

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a show-ahead receive FIFO, with
// sticky overrun/framing flags and an active-low interrupt request.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (8..65535)
//   FIFO_DEPTH    receive FIFO entries (power of two, 2..64)
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high
//   i_UART_TX     serial line, idle high (asynchronous to clk)
//   i_rd_strobe   one-clk pulse, pops the FIFO head
//   i_clr_errors  one-clk pulse, clears sticky overrun/framing flags
//   i_irq_en      interrupt enable
//   o_rx_data     FIFO head byte, 8'h00 when empty
//   o_rx_status   {3'b0, busy, framing, overrun, full, data_available}
//   o_IRQ         registered active-low interrupt request
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 289,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_UART_TX,
  input  logic       i_rd_strobe,
  input  logic       i_clr_errors,
  input  logic       i_irq_en,
  output logic [7:0] o_rx_data,
  output logic [7:0] o_rx_status,
  output logic       o_IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic             rx_p0, rx_p1;
  logic             vld_p0, vld_p1;
  logic             armed;
  state_t           state;
  logic [15:0]      timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovr_flag, frm_flag;
  logic             irq_n;

  logic data_tick, stop_tick, push_req, frame_set;
  logic empty, full, pop_ok, push_ok, ovr_set;

  // ---- stage p0/p1: line synchronizer ----
  // vld_pN marks when rx_pN holds a real line sample rather than its reset
  // value. The receiver only arms after seeing a genuine idle-high level, so
  // releasing reset while the line is low mid-frame cannot fake a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0  <= 1'b1;
      rx_p1  <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rx_p0  <= i_UART_TX;
      rx_p1  <= rx_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      if (vld_p1 && rx_p1) armed <= 1'b1;
    end
  end

  // ---- receiver FSM ----
  assign data_tick = (state == DATA) && (timer == BIT_LAST);
  assign stop_tick = (state == STOP) && (timer == BIT_LAST);
  assign push_req  = stop_tick && rx_p1;
  assign frame_set = stop_tick && !rx_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (armed && !rx_p1) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            // A start bit that is gone by mid-bit is treated as a glitch.
            state   <= rx_p1 ? IDLE : DATA;
            timer   <= '0;
            bit_idx <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= rx_p1 ? IDLE : WAIT_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold here through a break so it reports one framing error only.
          if (rx_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (data_tick) shift_reg[bit_idx] <= rx_p1;
  end

  // ---- receive FIFO ----
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = i_rd_strobe && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && (!full || pop_ok);
  assign ovr_set = push_req && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovr_flag <= 1'b0;
      frm_flag <= 1'b0;
      irq_n    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the clear cycle wins over the clear.
      if (ovr_set)           ovr_flag <= 1'b1;
      else if (i_clr_errors) ovr_flag <= 1'b0;
      if (frame_set)         frm_flag <= 1'b1;
      else if (i_clr_errors) frm_flag <= 1'b0;
      irq_n <= !(i_irq_en && (!empty || ovr_flag));
    end
  end

  // ---- outputs ----
  assign o_rx_data   = empty ? 8'h00 : mem[rd_ptr];
  assign o_rx_status = {3'b000, (state != IDLE), frm_flag, ovr_flag, full, !empty};
  assign o_IRQ       = irq_n;

endmodule
